// File: rtl/pipe_pkg.sv
// Shared pipeline constants: default widths and bit positions inside the 5-bit ctrl bundle.
package pipe_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned RegAwDef = 5;
  localparam int unsigned CtrlW    = 5;
  localparam int unsigned OutCtrlW = 4;

  localparam int unsigned BR  = 4;
  localparam int unsigned MR  = 3;
  localparam int unsigned MW  = 2;
  localparam int unsigned RW  = 1;
  localparam int unsigned M2R = 0;

endpackage

// File: rtl/stage_entry_reg.sv
// One pipeline slot: a valid flag plus a payload word, with load and clear.
module stage_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Clear wins over load so a flush always empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: two-entry skid buffer toward memory plus an early taken-branch redirect.
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned REG_AW = RegAwDef
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  input  logic [DATA_W-1:0]   store_data,
  input  logic [DATA_W-1:0]   branch_target,
  input  logic [REG_AW-1:0]   rd,
  input  logic [CtrlW-1:0]    ctrl,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_addr,
  output logic [DATA_W-1:0]   out_wdata,
  output logic [REG_AW-1:0]   out_rd,
  output logic [OutCtrlW-1:0] out_ctrl,
  output logic                redirect_valid,
  output logic [DATA_W-1:0]   redirect_pc
);

  localparam int unsigned PW = 2 * DATA_W + REG_AW + OutCtrlW;

  logic [PW-1:0] in_pl, head_pl, skid_pl, head_d;
  logic          head_v, skid_v, skid_v_d;
  logic          head_load, head_clear, skid_load, skid_clear;
  logic          accept, pop;
  logic          rdy_q, redir_q, redir_d;
  logic [DATA_W-1:0] pc_q;

  assign in_pl  = {alu_result, store_data, rd, ctrl[MR:M2R]};
  assign accept = in_valid && rdy_q;
  assign pop    = head_v && out_ready;

  always_comb begin
    head_load  = 1'b0;
    head_clear = 1'b0;
    head_d     = in_pl;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    skid_v_d   = skid_v;
    if (flush) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
      skid_v_d   = 1'b0;
    end else begin
      if (!head_v || pop) begin
        if (skid_v) begin
          head_load = 1'b1;
          head_d    = skid_pl;
        end else if (accept) begin
          head_load = 1'b1;
        end else begin
          head_clear = 1'b1;
        end
      end
      if (skid_v && pop) begin
        if (accept) begin
          skid_load = 1'b1;
        end else begin
          skid_clear = 1'b1;
          skid_v_d   = 1'b0;
        end
      end else if (!skid_v && accept && head_v && !pop) begin
        skid_load = 1'b1;
        skid_v_d  = 1'b1;
      end
    end
  end

  assign redir_d = accept && !flush && ctrl[BR] && alu_zero;

  // in_ready tracks the next skid state from a flop, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      redir_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      rdy_q   <= !skid_v_d;
      redir_q <= redir_d;
      if (redir_d) begin
        pc_q <= branch_target;
      end
    end
  end

  stage_entry_reg #(
    .W(PW)
  ) u_head (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (head_load),
    .clear_i(head_clear),
    .d_i    (head_d),
    .valid_o(head_v),
    .q_o    (head_pl)
  );

  stage_entry_reg #(
    .W(PW)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .clear_i(skid_clear),
    .d_i    (in_pl),
    .valid_o(skid_v),
    .q_o    (skid_pl)
  );

  assign in_ready       = rdy_q;
  assign out_valid      = head_v;
  assign {out_addr, out_wdata, out_rd, out_ctrl} = head_pl;
  assign redirect_valid = redir_q;
  assign redirect_pc    = pc_q;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning ALU result, store data and branch target width.
REQ-002 SHALL have parameter REG_AW, default 5, meaning destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  execute stage presents a valid entry.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port alu_result  input  DATA_W  ALU Result, also used as the memory address.
REQ-008 SHALL have port alu_zero  input  1  ALU Zero flag.
REQ-009 SHALL have port store_data, branch_target  input  DATA_W each  rs2 value for stores; computed branch PC.
REQ-010 SHALL have port rd  input  REG_AW  destination register.
REQ-011 SHALL have port ctrl  input  5  {branch, mem_read, mem_write, reg_write, mem_to_reg}.
REQ-012 SHALL have port flush  input  1  discard all held entries.
REQ-013 SHALL have port out_valid  output  1  head entry valid toward the memory stage.
REQ-014 SHALL have port out_ready  input  1  memory stage accepts the head entry.
REQ-015 SHALL have port out_addr, out_wdata  output  DATA_W each  head alu_result and store_data.
REQ-016 SHALL have port out_rd, out_ctrl  output  REG_AW, 4  head rd; ctrl without the branch bit.
REQ-017 SHALL have port redirect_valid, redirect_pc  output  1, DATA_W  taken-branch pulse and target.

Function
REQ-018 SHALL hold up to two entries: head register (drives outputs) and skid register.
REQ-019 SHALL drive in_ready = !skid_valid, registered, with no combinational path from out_ready.
REQ-020 SHALL accept an entry on in_valid && in_ready; the head pops on out_valid && out_ready.
REQ-021 SHALL load the accepted entry into the head when the head is empty or popping, else into skid.
REQ-022 SHALL move skid into the head on the pop cycle when skid is valid; an accept in that same cycle goes into skid.
REQ-023 SHALL keep entries in FIFO order; zero-bubble throughput, so one entry per cycle sustains with out_ready high.
REQ-024 SHALL give a latency of one cycle from accept to out_valid when empty.
REQ-025 SHALL compute taken = ctrl.branch && alu_zero (BEQ) at accept.
REQ-026 SHALL pulse redirect_valid for exactly one cycle, the cycle after accept, with redirect_pc = branch_target.
REQ-027 SHALL not wait for the entry to drain before issuing the redirect.
REQ-028 SHALL clear both entries on flush at the next edge; flush overrides a simultaneous accept (entry dropped) and pop.
REQ-029 SHALL suppress the redirect of an entry accepted in a flush cycle.
REQ-030 SHALL hold out_* stable while out_valid && !out_ready.
REQ-031 SHALL accept no entry while full (in_valid ignored).
REQ-032 SHALL store every field unmodified at full width, with no arithmetic on data.

Reset
REQ-033 SHALL, while rst_n = 0, force out_valid = 0, redirect_valid = 0, in_ready = 0 and both valid flags = 0.
REQ-034 SHALL force all data outputs to 0 during reset.
REQ-035 SHALL raise in_ready on the first edge after deassertion.
REQ-036 SHALL discard in-flight entries and any pending redirect on reset mid-operation.

Structure
REQ-037 SHALL place DATA_W/REG_AW defaults and ctrl bit-index constants (BR, MR, MW, RW, M2R) in a shared package, pipe_pkg.
REQ-038 SHALL contain one sub-module, stage_entry_reg: a valid+payload register with load/clear.
REQ-039 SHALL instantiate stage_entry_reg twice, for head and skid.

Verification
REQ-040 Single entry: accept alu_result=0x10, rd=3, ctrl=RW, out_ready=1 -> out_valid one cycle later, out_addr=0x10, out_rd=3, then empty.
REQ-041 Backpressure: out_ready=0, send 0x1, 0x2, 0x3 -> 0x1 and 0x2 held, in_ready=0 after the second accept, 0x3 waits.
REQ-042 Backpressure release: raise out_ready -> order 0x1, 0x2, 0x3 with no loss or duplicate.
REQ-043 Branch: ctrl.branch=1, alu_zero=1, target=0x400 -> redirect_valid pulse one cycle, pc=0x400.
REQ-044 Branch not taken: alu_zero=0 -> no redirect pulse.
REQ-045 Flush with two held entries plus a simultaneous accept -> next cycle out_valid=0, in_ready=1, no redirect.
REQ-046 Assert rst_n=0 mid-stream, asynchronous to clk -> outputs 0 immediately; after release the first new entry emerges correctly.
